apb_cfg_master: RTL and testbench
=================================

// Module: apb_cfg_master
// PURPOSE
//  APB initiator that loads and reads back the vending machine item table
//  through the vending controller's APB config port.
//  Accepts one host command at a time (write or read of one item entry) and
//  runs one APB transfer (SETUP then ACCESS, waiting on pready).
//  Returns read data or error status to the host over a valid/ready response.
//  Holds cfg_mode high for the whole transfer so the slave stays in config mode.
// PARAMETERS
//  MAX_ITEMS   1024  number of item entries; valid cmd_index is 0..MAX_ITEMS-1
//  TIMEOUT     255   ACCESS cycles without pready before the transfer is aborted
//  BASE_ADDR   4     byte address of entry 0; entry n is at BASE_ADDR + 4*n
// PORTS
//  pclk         in   1   clock
//  prst         in   1   synchronous active-high reset
//  cmd_valid    in   1   host command present
//  cmd_ready    out  1   block accepts a command (high only in IDLE)
//  cmd_write    in   1   1 = write entry, 0 = read entry
//  cmd_index    in   10  item entry index
//  cmd_wdata    in   32  entry {empty[31],dispensed[30:24],available[23:16],cost[15:0]}
//  rsp_valid    out  1   response present; held until rsp_ready
//  rsp_ready    in   1   host takes the response
//  rsp_rdata    out  32  read data (0 for writes and on error)
//  rsp_err      out  2   0 = ok, 1 = timeout, 2 = bad index, 3 = verify mismatch
//  cfg_mode     out  1   config-mode request to the slave
//  psel         out  1   APB select
//  penable      out  1   APB enable
//  pwrite       out  1   APB direction
//  paddr        out  15  APB byte address
//  pwdata       out  32  APB write data
//  prdata       in   32  APB read data
//  pready       in   1   APB ready
// BEHAVIOUR
//  - One clock (pclk). Reset is synchronous and active-high (prst).
//  - Reset values: all outputs 0 except cmd_ready = 1. FSM returns to IDLE.
//    Reset during a transfer drops psel/penable/cfg_mode at that edge and
//    discards the pending response.
//  - FSM states: IDLE -> SETUP -> ACCESS -> RESP -> IDLE.
//  - IDLE, cmd_valid & cmd_ready:
//    - latch the command.
//    - if cmd_index >= MAX_ITEMS, go to RESP with rsp_err = 2 and issue no
//      APB cycle.
//    - otherwise go to SETUP.
//  - SETUP (1 cycle): psel = 1, penable = 0, cfg_mode = 1.
//    paddr = BASE_ADDR + {cmd_index,2'b00}, truncated to 15 bits.
//    pwrite and pwdata are driven from the latched command.
//  - ACCESS: psel = 1, penable = 1; address, data and control held stable.
//    Wait counter starts at 0.
//    - pready = 1: capture prdata (reads only) and go to RESP with rsp_err = 0.
//    - counter reaches TIMEOUT with no pready: go to RESP with rsp_err = 1
//      and rsp_rdata = 0.
//  - RESP: psel, penable and cfg_mode are 0; rsp_valid = 1.
//    - rsp_valid & rsp_ready: go to IDLE.
//    - rsp_valid with rsp_ready low: hold rsp_rdata and rsp_err stable.
//  - Latency: a write with pready returned on the first ACCESS cycle gives
//    cmd accept -> rsp_valid = 3 cycles.
//  - Back-to-back commands are separated by at least one idle APB cycle.
//  - A command presented while busy is not accepted (cmd_ready low); the
//    host holds it.
// CONFIGURATION
//  - APB_VERIFY_EN defined: a write that completes ok is followed by an
//    automatic read of the same address (states VSETUP -> VACCESS).
//    - read data != written data: rsp_err = 3.
//    - read times out: rsp_err = 1.
//    - rsp_rdata returns the read-back value.
//  - APB_VERIFY_EN undefined: writes end after a single ACCESS; rsp_err = 3
//    never occurs.
// TESTING
//  1. Reset, then write idx 5, data 0x0003_0032, pready on the first ACCESS
//     cycle -> paddr = 0x0018, pwrite = 1, psel/penable sequence 10 -> 11,
//     rsp_valid at cycle 3, rsp_err = 0.
//  2. Read idx 1023, slave returns 0x8000_0064 after 2 wait cycles ->
//     paddr = 0x1000, rsp_rdata = 0x8000_0064, rsp_err = 0.
//  3. Read idx 7 with pready held low, TIMEOUT = 4 -> psel drops after 4
//     ACCESS cycles, rsp_err = 1, rsp_rdata = 0.
//  4. cmd_index = 1024 with MAX_ITEMS = 1024 -> no psel pulse, rsp_err = 2.
//  5. rsp_ready held low for 10 cycles, then cmd_valid asserted -> cmd_ready
//     stays 0 and the response stays stable until rsp_ready rises.
//  6. Assert prst during ACCESS -> psel/penable/cfg_mode = 0 the next cycle,
//     no rsp_valid.
//     With APB_VERIFY_EN: write 0x11, slave reads back 0x10 -> rsp_err = 3.

Source files
------------

// File: rtl/apb_cfg_master.sv
// APB initiator that writes and reads back vending item-table entries for a host.
// Optional feature: define APB_VERIFY_EN to read back each successful write and compare the data.
module apb_cfg_master #(
    parameter int MAX_ITEMS = 1024,
    parameter int TIMEOUT   = 255,
    parameter int BASE_ADDR = 4,
    parameter int IDX_W     = 10
) (
    input  logic             pclk,
    input  logic             prst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_write,
    input  logic [IDX_W-1:0] cmd_index,
    input  logic [31:0]      cmd_wdata,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_rdata,
    output logic [1:0]       rsp_err,
    output logic             cfg_mode,
    output logic             psel,
    output logic             penable,
    output logic             pwrite,
    output logic [14:0]      paddr,
    output logic [31:0]      pwdata,
    input  logic [31:0]      prdata,
    input  logic             pready
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, SETUP, ACCESS, VSETUP, VACCESS, RESP} state_t;

    state_t        state, next;
    logic [CW-1:0] cnt;
    logic          wr_q;
    logic [14:0]   addr_q;
    logic [31:0]   wdata_q;
    logic [31:0]   rdata_q;
    logic [1:0]    err_q;
    logic          bad_idx;
    logic          timed_out;

    assign bad_idx   = 32'(cmd_index) >= 32'(MAX_ITEMS);
    assign timed_out = (cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge pclk) begin
        if (prst) state <= IDLE;
        else      state <= next;
    end

    always_comb begin
        next = state;
        case (state)
            IDLE:    if (cmd_valid) next = bad_idx ? RESP : SETUP;
            SETUP:   next = ACCESS;
            ACCESS: begin
`ifdef APB_VERIFY_EN
                if (pready)         next = wr_q ? VSETUP : RESP;
`else
                if (pready)         next = RESP;
`endif
                else if (timed_out) next = RESP;
            end
            VSETUP:  next = VACCESS;
            VACCESS: if (pready || timed_out) next = RESP;
            RESP:    if (rsp_ready) next = IDLE;
            default: next = IDLE;
        endcase
    end

    // Response fields are cleared at accept so writes and errors report rdata = 0.
    always_ff @(posedge pclk) begin
        if (prst) begin
            cnt     <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= '0;
        end else begin
            case (state)
                IDLE: if (cmd_valid) begin
                    wr_q    <= cmd_write;
                    addr_q  <= 15'(32'(BASE_ADDR) + 32'({cmd_index, 2'b00}));
                    wdata_q <= cmd_wdata;
                    rdata_q <= '0;
                    err_q   <= bad_idx ? 2'd2 : 2'd0;
                end
                SETUP, VSETUP: cnt <= '0;
                ACCESS: begin
                    cnt <= cnt + 1'b1;
                    if (pready) begin
                        if (!wr_q) rdata_q <= prdata;
                    end else if (timed_out) begin
                        err_q <= 2'd1;
                    end
                end
                VACCESS: begin
                    cnt <= cnt + 1'b1;
                    if (pready) begin
                        rdata_q <= prdata;
                        err_q   <= (prdata != wdata_q) ? 2'd3 : 2'd0;
                    end else if (timed_out) begin
                        rdata_q <= '0;
                        err_q   <= 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign cmd_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign psel      = (state == SETUP) || (state == ACCESS) || (state == VSETUP) || (state == VACCESS);
    assign penable   = (state == ACCESS) || (state == VACCESS);
    assign cfg_mode  = psel;
    // Read-back phase of a verified write is an APB read.
    assign pwrite    = wr_q && ((state == SETUP) || (state == ACCESS));
    assign paddr     = addr_q;
    assign pwdata    = wdata_q;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
endmodule

// File: tb/tb_apb_cfg_master.sv
// Directed bench for apb_cfg_master with a small wait-state APB slave model.
// Build with APB_VERIFY_EN defined to exercise the write read-back path.
module tb_apb_cfg_master;
    logic        pclk = 1'b0;
    logic        prst;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [10:0] cmd_index;
    logic [31:0] cmd_wdata;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_err;
    logic        cfg_mode, psel, penable, pwrite;
    logic [14:0] paddr;
    logic [31:0] pwdata, prdata;
    logic        pready;

    int cmps = 0;
    int errs = 0;
    int slave_wait = 0;
    int acc_cnt = 0;
    logic [31:0] slave_prdata = '0;

`ifdef APB_VERIFY_EN
    localparam bit VER = 1'b1;
`else
    localparam bit VER = 1'b0;
`endif

    apb_cfg_master #(.MAX_ITEMS(1024), .TIMEOUT(4), .BASE_ADDR(4), .IDX_W(11)) dut (
        .pclk(pclk), .prst(prst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_index(cmd_index), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .cfg_mode(cfg_mode), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready)
    );

    always #5 pclk = ~pclk;

    // Slave: pready after slave_wait wait states in ACCESS.
    assign pready = psel && penable && (acc_cnt == slave_wait);
    assign prdata = slave_prdata;
    always @(posedge pclk) acc_cnt <= (psel && penable && !pready) ? acc_cnt + 1 : 0;

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        cmps++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic        w;
        logic [10:0] idx;
        logic [31:0] wd;
        int          wt;
        logic [31:0] rd;
        logic [14:0] e_addr;
        int          e_psel;
        int          e_lat;
        logic [31:0] e_rdata;
        logic [1:0]  e_err;
    } vec_t;

    vec_t vecs[6];

    // Present one command, follow it to rsp_valid, record what the APB side did.
    task automatic run_cmd(input logic w, input logic [10:0] idx, input logic [31:0] wd,
                           output int lat, output logic [14:0] addr, output logic pw,
                           output int pcyc, output logic seq_ok, output logic cfg_ok,
                           output logic done);
        logic first;
        cmd_valid = 1'b1; cmd_write = w; cmd_index = idx; cmd_wdata = wd;
        tick();
        cmd_valid = 1'b0;
        lat = 1; pcyc = 0; seq_ok = 1'b1; cfg_ok = 1'b1; done = 1'b0; first = 1'b1;
        addr = '0; pw = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            if (cfg_mode !== psel) cfg_ok = 1'b0;
            if (rsp_valid) begin
                done = 1'b1;
            end else begin
                if (psel) begin
                    if (first) begin
                        addr = paddr; pw = pwrite;
                        if (penable) seq_ok = 1'b0;
                        first = 1'b0;
                    end else if (pcyc == 1 && !penable) begin
                        seq_ok = 1'b0;
                    end
                    pcyc++;
                end
                tick();
                lat++;
            end
        end
    endtask

    task automatic take_rsp();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    initial begin
        int lat, pcyc;
        logic [14:0] addr;
        logic pw, seq_ok, cfg_ok, done;
        logic [31:0] hold_rdata;
        logic [1:0]  hold_err;

        prst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_index = '0; cmd_wdata = '0;
        rsp_ready = 1'b0;

        vecs[0] = '{1'b1, 11'd5,    32'h0003_0032, 0,   32'h0003_0032, 15'h0018,
                    VER ? 4 : 2, VER ? 5 : 3, VER ? 32'h0003_0032 : 32'h0, 2'd0};
        vecs[1] = '{1'b0, 11'd1023, 32'h0,         2,   32'h8000_0064, 15'h1000,
                    4, 5, 32'h8000_0064, 2'd0};
        vecs[2] = '{1'b0, 11'd7,    32'h0,         255, 32'hFFFF_FFFF, 15'h0020,
                    5, 6, 32'h0, 2'd1};
        vecs[3] = '{1'b0, 11'd1024, 32'h0,         0,   32'h1234_5678, 15'h0000,
                    0, 1, 32'h0, 2'd2};
        vecs[4] = '{1'b1, 11'd0,    32'hDEAD_BEEF, 1,   32'hDEAD_BEEF, 15'h0004,
                    VER ? 6 : 3, VER ? 7 : 4, VER ? 32'hDEAD_BEEF : 32'h0, 2'd0};
        vecs[5] = '{1'b0, 11'd2,    32'h0,         0,   32'h1234_5678, 15'h000C,
                    2, 3, 32'h1234_5678, 2'd0};

        repeat (3) tick();
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_apb_ctl",   {29'd0, psel, penable, cfg_mode}, 32'd0);
        chk("rst_pwrite",    32'(pwrite), 32'd0);
        chk("rst_paddr",     32'(paddr), 32'd0);
        chk("rst_pwdata",    pwdata, 32'd0);
        chk("rst_rsp",       {rsp_err, rsp_rdata[29:0]} | {30'd0, rsp_rdata[31:30]}, 32'd0);
        prst = 1'b0;
        tick();

        foreach (vecs[i]) begin
            slave_wait = vecs[i].wt; slave_prdata = vecs[i].rd;
            run_cmd(vecs[i].w, vecs[i].idx, vecs[i].wd, lat, addr, pw, pcyc, seq_ok, cfg_ok, done);
            chk($sformatf("v%0d_done", i), 32'(done), 32'd1);
            chk($sformatf("v%0d_lat", i), 32'(lat), 32'(vecs[i].e_lat));
            chk($sformatf("v%0d_psel_cycles", i), 32'(pcyc), 32'(vecs[i].e_psel));
            if (vecs[i].e_psel != 0) begin
                chk($sformatf("v%0d_paddr", i), 32'(addr), 32'(vecs[i].e_addr));
                chk($sformatf("v%0d_pwrite", i), 32'(pw), 32'(vecs[i].w));
                chk($sformatf("v%0d_setup_access", i), 32'(seq_ok), 32'd1);
            end
            chk($sformatf("v%0d_cfg_mode", i), 32'(cfg_ok), 32'd1);
            chk($sformatf("v%0d_rdata", i), rsp_rdata, vecs[i].e_rdata);
            chk($sformatf("v%0d_err", i), 32'(rsp_err), 32'(vecs[i].e_err));
            take_rsp();
            chk($sformatf("v%0d_back_idle", i), {30'd0, rsp_valid, cmd_ready}, 32'd1);
        end

        // Response held while host stalls; a pending command is not accepted.
        slave_wait = 0; slave_prdata = 32'hA5A5_0001;
        run_cmd(1'b0, 11'd3, 32'h0, lat, addr, pw, pcyc, seq_ok, cfg_ok, done);
        chk("hold_done", 32'(done), 32'd1);
        hold_rdata = rsp_rdata; hold_err = rsp_err;
        chk("hold_rdata0", hold_rdata, 32'hA5A5_0001);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_index = 11'd9; cmd_wdata = 32'h55;
        begin
            logic stable = 1'b1;
            for (int c = 0; c < 10; c++) begin
                tick();
                if (cmd_ready !== 1'b0 || rsp_valid !== 1'b1 || psel !== 1'b0 ||
                    rsp_rdata !== hold_rdata || rsp_err !== hold_err) stable = 1'b0;
            end
            chk("hold_stable", 32'(stable), 32'd1);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        cmd_valid = 1'b0;
        chk("hold_release", {30'd0, rsp_valid, cmd_ready}, 32'd1);
        tick();

        // Reset in the middle of ACCESS.
        slave_wait = 255;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_index = 11'd9;
        tick();
        cmd_valid = 1'b0;
        tick();
        chk("mid_access", {30'd0, psel, penable}, 32'd3);
        prst = 1'b1;
        tick();
        chk("rst_mid_apb", {29'd0, psel, penable, cfg_mode}, 32'd0);
        chk("rst_mid_rsp", 32'(rsp_valid), 32'd0);
        prst = 1'b0;
        begin
            logic quiet = 1'b1;
            for (int c = 0; c < 4; c++) begin
                tick();
                if (rsp_valid !== 1'b0 || psel !== 1'b0 || cmd_ready !== 1'b1) quiet = 1'b0;
            end
            chk("rst_mid_quiet", 32'(quiet), 32'd1);
        end

`ifdef APB_VERIFY_EN
        // Read-back differs from written data.
        slave_wait = 0; slave_prdata = 32'h10;
        run_cmd(1'b1, 11'd4, 32'h11, lat, addr, pw, pcyc, seq_ok, cfg_ok, done);
        chk("ver_done", 32'(done), 32'd1);
        chk("ver_err", 32'(rsp_err), 32'd3);
        chk("ver_rdata", rsp_rdata, 32'h10);
        take_rsp();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
        $finish;
    end
endmodule
